// File: rtl/mux_scan_seq_pkg.sv
// Shared types and constants for the serial word scanner.
package mux_scan_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;

  // Scanner occupancy: nothing, active word only, active plus held word.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SCAN      = 2'd1,
    ST_SCAN_HELD = 2'd2
  } scan_state_e;

  // First select of a word for the chosen scan direction.
  function automatic logic [SEL_W-1:0] SEL_FIRST(input bit msb_first);
    return msb_first ? 4'd15 : 4'd0;
  endfunction

  // Final select of a word for the chosen scan direction.
  function automatic logic [SEL_W-1:0] SEL_LAST(input bit msb_first);
    return msb_first ? 4'd0 : 4'd15;
  endfunction

endpackage

// File: rtl/mux_scan_seq_if.sv
// Word-in / bit-out handshake bundle for the scanner.
interface mux_scan_seq_if;
  import mux_scan_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              out_bit;
  logic [SEL_W-1:0]  out_sel;
  logic              out_last;
  logic              busy;

  // Scanner side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bit, out_sel, out_last, busy
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bit, out_sel, out_last, busy
  );
endinterface

// File: rtl/mux_scan_seq_mux.sv
// 16:1 bit selector driven by the scanner.
module mux_16_1 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out
);
  assign out = in[sel];
endmodule

// File: rtl/mux_scan_seq.sv
// Scans 16-bit words out one bit per accepted beat through a 16:1 mux,
// with a one-word holding register for gapless word-to-word streaming.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_seq_if.slave  bus
);

  localparam logic [SEL_W-1:0] START_SEL = SEL_FIRST(MSB_FIRST);
  localparam logic [SEL_W-1:0] END_SEL   = SEL_LAST(MSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};

  scan_state_e       state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_d;
  logic [WORD_W-1:0] active_q;
  logic [WORD_W-1:0] hold_q;

  logic act_full_s;
  logic hold_full_s;
  logic in_fire_s;
  logic out_fire_s;
  logic last_s;
  logic out_bit_s;

  assign act_full_s  = (state_q != ST_IDLE);
  assign hold_full_s = (state_q == ST_SCAN_HELD);
  assign in_fire_s   = bus.in_valid & ~hold_full_s;
  assign out_fire_s  = act_full_s & bus.out_ready;
  assign last_s      = act_full_s & (sel_q == END_SEL);

  // Next select within a word; only used when the current beat is not the last.
  always_comb begin
    sel_d = sel_q;
    if (MSB_FIRST) begin
      sel_d = sel_q - SEL_ONE;
    end else begin
      sel_d = sel_q + SEL_ONE;
    end
  end

  // Occupancy FSM plus active/hold word and select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= START_SEL;
      active_q <= 16'h0000;
      hold_q   <= 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_fire_s) begin
            active_q <= bus.in_data;
            sel_q    <= START_SEL;
            state_q  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (out_fire_s && last_s) begin
            if (in_fire_s) begin
              // Word ends and the next one arrives together: bypass the hold slot.
              active_q <= bus.in_data;
              sel_q    <= START_SEL;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            if (out_fire_s) begin
              sel_q <= sel_d;
            end
            if (in_fire_s) begin
              hold_q  <= bus.in_data;
              state_q <= ST_SCAN_HELD;
            end
          end
        end
        ST_SCAN_HELD: begin
          if (out_fire_s) begin
            if (last_s) begin
              active_q <= hold_q;
              sel_q    <= START_SEL;
              state_q  <= ST_SCAN;
            end else begin
              sel_q <= sel_d;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  mux_16_1 u_mux (
    .in  (active_q),
    .sel (sel_q),
    .out (out_bit_s)
  );

  assign bus.in_ready  = ~hold_full_s;
  assign bus.out_valid = act_full_s;
  assign bus.out_bit   = out_bit_s;
  assign bus.out_sel   = sel_q;
  assign bus.out_last  = last_s;
  assign bus.busy      = act_full_s | hold_full_s;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: LSB-first and MSB-first instances.
module tb_mux_scan_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_scan_seq_if bus0 ();
  mux_scan_seq_if bus1 ();

  mux_scan_seq #(.MSB_FIRST(1'b0)) u_dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  mux_scan_seq #(.MSB_FIRST(1'b1)) u_dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected beats for 16'h3f0a, sel 0..15.
  logic beats_a [16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Full beat check on the LSB-first instance.
  task automatic chk_lsb(input string tag, input int i, input logic [3:0] sel, input logic b, input logic last);
    check_val($sformatf("%s_valid%0d", tag, i), 32'(bus0.out_valid), 32'd1);
    check_val($sformatf("%s_sel%0d", tag, i), 32'(bus0.out_sel), 32'(sel));
    check_val($sformatf("%s_bit%0d", tag, i), 32'(bus0.out_bit), 32'(b));
    check_val($sformatf("%s_last%0d", tag, i), 32'(bus0.out_last), 32'(last));
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = 16'h0000; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = 16'h0000; bus1.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset-time outputs.
    check_val("rst_valid", 32'(bus0.out_valid), 32'd0);
    check_val("rst_ready", 32'(bus0.in_ready), 32'd1);
    check_val("rst_last", 32'(bus0.out_last), 32'd0);
    check_val("rst_busy", 32'(bus0.busy), 32'd0);
    check_val("rst_sel", 32'(bus0.out_sel), 32'd0);
    check_val("rst_bit", 32'(bus0.out_bit), 32'd0);
    check_val("rst_sel_msb", 32'(bus1.out_sel), 32'd15);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word 16'h3f0a, LSB first.
    bus0.in_valid = 1'b1; bus0.in_data = 16'h3f0a;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_lsb("w3f0a", i, 4'(i), beats_a[i], (i == 15));
      @(negedge clk);
    end
    check_val("w3f0a_idle_valid", 32'(bus0.out_valid), 32'd0);
    check_val("w3f0a_idle_busy", 32'(bus0.busy), 32'd0);
    check_val("w3f0a_idle_sel", 32'(bus0.out_sel), 32'd15);

    // MSB-first word 16'h8001.
    bus1.in_valid = 1'b1; bus1.in_data = 16'h8001;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("msb_valid%0d", i), 32'(bus1.out_valid), 32'd1);
      check_val($sformatf("msb_sel%0d", i), 32'(bus1.out_sel), 32'(15 - i));
      check_val($sformatf("msb_bit%0d", i), 32'(bus1.out_bit), ((i == 0) || (i == 15)) ? 32'd1 : 32'd0);
      check_val($sformatf("msb_last%0d", i), 32'(bus1.out_last), (i == 15) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check_val("msb_idle_valid", 32'(bus1.out_valid), 32'd0);

    // Back-to-back 16'hffff then 16'h0000.
    bus0.in_valid = 1'b1; bus0.in_data = 16'hffff;
    @(negedge clk);
    bus0.in_data = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      if (i == 1) begin
        bus0.in_valid = 1'b0;
        check_val("b2b_ready_held", 32'(bus0.in_ready), 32'd0);
        check_val("b2b_busy_held", 32'(bus0.busy), 32'd1);
      end
      if (i == 16) begin
        check_val("b2b_ready_free", 32'(bus0.in_ready), 32'd1);
      end
      chk_lsb("b2b", i, 4'(i % 16), (i < 16), ((i % 16) == 15));
      @(negedge clk);
    end
    check_val("b2b_idle_valid", 32'(bus0.out_valid), 32'd0);

    // Backpressure at sel 5 on 16'h00a0 (bits 5 and 7 set).
    bus0.in_valid = 1'b1; bus0.in_data = 16'h00a0;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_lsb("bp", i, 4'(i), ((i == 5) || (i == 7)), (i == 15));
      if (i == 5) begin
        bus0.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk_lsb($sformatf("bp_stall%0d", k), i, 4'd5, 1'b1, 1'b0);
        end
        bus0.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    check_val("bp_idle_valid", 32'(bus0.out_valid), 32'd0);

    // Reset mid-scan at sel 7 with the hold register full.
    bus0.in_valid = 1'b1; bus0.in_data = 16'hffff;
    @(negedge clk);
    bus0.in_data = 16'h1234;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) bus0.in_valid = 1'b0;
      @(negedge clk);
    end
    check_val("mid_sel7", 32'(bus0.out_sel), 32'd7);
    check_val("mid_ready_held", 32'(bus0.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(bus0.out_valid), 32'd0);
    check_val("mid_rst_ready", 32'(bus0.in_ready), 32'd1);
    check_val("mid_rst_busy", 32'(bus0.busy), 32'd0);
    check_val("mid_rst_sel", 32'(bus0.out_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.in_data = 16'h0001;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    chk_lsb("post_rst", 0, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk_lsb("post_rst", 1, 4'd1, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    check_val("post_rst_idle", 32'(bus0.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Sequencer that sits directly upstream of the 16:1 bit mux. It accepts 16-bit words over a valid/ready handshake and drives the mux select 0..15, one step per accepted output beat. It presents the selected bit as a serial stream with valid/ready and a last-beat flag. A one-entry holding register lets the next word be accepted while the current word is still being scanned, giving zero-bubble word-to-word streaming.

## Interface
Parameters:
- `MSB_FIRST`, default 0: 0 = select sequence 0→15; 1 = select sequence 15→0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  16  word to scan.
- `in_ready`  out  1  block can take a word; equals `!hold_full`.
- `out_valid`  out  1  `out_bit` is valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_bit`  out  1  `active_word[sel]` through the mux.
- `out_sel`  out  4  current select value (the mux `sel`).
- `out_last`  out  1  current beat is the final select of the word.
- `busy`  out  1  `out_valid | hold_full`.

## Operation
- State: `active_word[15:0]`, `sel[3:0]`, `act_full` (drives `out_valid`), `hold_word[15:0]`, `hold_full`.
- `in_fire = in_valid & in_ready`. `out_fire = out_valid & out_ready`.
- `start_sel`: 0 when `MSB_FIRST=0`, 15 when `MSB_FIRST=1`. `end_sel` is the opposite value.
- `out_last = act_full & (sel == end_sel)`.
- FSM states, encoded in the shared package:
  - IDLE: `!act_full`, `!hold_full`.
  - SCAN: `act_full`, `!hold_full`.
  - SCAN_HELD: `act_full`, `hold_full`.
- Word load rules, evaluated each edge:
  - IDLE and `in_fire`: load `in_data` into `active_word`, set `sel <= start_sel`, go to SCAN.
  - SCAN, `out_fire`, not `out_last`: step `sel` by ±1.
  - SCAN, `out_fire & out_last`:
    - With `in_fire` the same cycle: bypass `in_data` into `active_word`, `sel <= start_sel`, stay in SCAN.
    - Otherwise: go to IDLE.
  - SCAN, `in_fire`, no last-beat completion: write `in_data` to `hold_word`, go to SCAN_HELD.
  - SCAN_HELD, `out_fire & out_last`: move `hold_word` into `active_word`, `sel <= start_sel`, go to SCAN. `in_ready` is 0 in this state, so there is no simultaneous input.
- No backpressure (`out_valid & !out_ready`): `sel`, `active_word` and `out_bit` are held stable.
- `sel` never wraps on its own. The step after `end_sel` is always a reload or IDLE.
- In IDLE, `out_sel` holds its last value and `out_bit` is don't-care.

## Timing
- Reset values: `act_full=0`, `hold_full=0`, `sel=start_sel`, `active_word=0`, `hold_word=0`.
- Reset-time outputs: `out_valid=0`, `in_ready=1`, `out_last=0`, `busy=0`, `out_sel=start_sel`, `out_bit=0`.
- Latency: a word accepted at edge N has its first beat valid from cycle N+1.
- A word takes at least 16 `out_fire` cycles.
- Sustained throughput is 1 bit/cycle with no gap between words when upstream keeps the hold register filled.
- `out_bit`, `out_sel` and `out_last` are combinational from registered state only. There is no path from `out_ready` or `in_valid` to them.
- `in_ready` is registered-derived (`!hold_full`).
- Reset asserted mid-scan: all state clears immediately (asynchronous), and both in-flight words are discarded. After deassertion, the first edge behaves as IDLE.

## Structure
- Shared package `mux_scan_pkg`:
  - State enum (IDLE/SCAN/SCAN_HELD).
  - `WORD_W=16`, `SEL_W=4`.
  - `SEL_FIRST`/`SEL_LAST` constant functions of `MSB_FIRST`.
- Sub-module: instantiate the existing `mux_16_1` as the bit selector, with `in` = `active_word`, `sel` = `sel`, `out` = `out_bit`. Do not re-implement the select in this block.

## Test plan
- Reset then single word: `in_data=16'h3f0a`, `out_ready=1` → beats 1–16 are `0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0`. `out_last` is set only at sel=15, then the block returns to IDLE.
- Spot values on the same word: sel 0 → 0, sel 1 → 1, sel 6 → 0, sel 12 → 1.
- `MSB_FIRST=1`, `in_data=16'h8001` → first beat: `out_sel=15`, bit 1. Beats 2–15 are 0. Last beat: `out_sel=0`, bit 1, `out_last=1`.
- Back-to-back: `16'hffff` then `16'h0000` offered continuously, `out_ready=1`:
  - Second word lands in hold; `in_ready` drops.
  - 32 consecutive beats with `out_valid` never low: sixteen 1s then sixteen 0s.
  - `out_sel` jumps 15→0 with no bubble.
- Backpressure: `out_ready=0` for 3 cycles at sel=5 → `out_sel`, `out_bit` and `out_valid` hold. Scan resumes at sel=5 with no skipped or duplicated beat.
- Reset mid-scan: `rst_n` low at sel=7 with the hold register full → `out_valid=0`, `in_ready=1` and `busy=0` immediately, before the next edge. A new word then starts at sel=0.
